map_rect_writer: RTL and testbench

- Writer side of the 160x120 background map memory: 4-bit palette indices, address = x + y*160, the same layout the map renderer reads.
- Accepts rectangle commands over a valid/ready handshake and writes them into the map RAM's write port, one pixel per cycle.
- Two modes: FILL (write every pixel) and RECOLOR (read-modify-write, e.g. palette index 0 red -> 8 dead red).
- Sits between game logic and a dual-port map RAM; the VGA read port is untouched.

---
 rtl/map_rect_writer.sv | 131 +++++++++++++
 tb/tb_map_rect_writer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_rect_writer.sv
// Rectangle writer for the 160x120 4-bit background map: FILL writes every clipped pixel,
// RECOLOR does a read-compare-write per pixel through the map RAM's synchronous read port.
module map_rect_writer #(
  parameter int MAP_W  = 160,
  parameter int MAP_H  = 120,
  parameter int ADDR_W = 17
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [7:0]        cmd_x0_i,
  input  logic [6:0]        cmd_y0_i,
  input  logic [7:0]        cmd_w_i,
  input  logic [6:0]        cmd_h_i,
  input  logic [3:0]        cmd_color_i,
  input  logic              cmd_recolor_i,
  input  logic [3:0]        cmd_match_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [3:0]        rd_data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [3:0]        wr_data_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_RD, S_CMP, S_DONE} state_t;

  localparam logic [8:0] MAP_W9 = 9'(MAP_W);
  localparam logic [8:0] MAP_H9 = 9'(MAP_H);

  state_t            state_q, state_d;
  logic [8:0]        x_q, x0_q, x_end_q, y_q, y_end_q;
  logic [ADDR_W-1:0] row_q;
  logic [3:0]        color_q, match_q;

  logic              accept, empty, x_last, last, step;
  logic [8:0]        x_sum, y_sum, x_clip, y_clip;
  logic [ADDR_W-1:0] row_init, addr;

  assign cmd_ready_o = (state_q == S_IDLE) && !reset_i;
  assign accept      = cmd_valid_i && cmd_ready_o;

  // Clip against the map edge once, at acceptance, in 9-bit arithmetic.
  assign x_sum  = {1'b0, cmd_x0_i} + {1'b0, cmd_w_i};
  assign y_sum  = {2'b0, cmd_y0_i} + {2'b0, cmd_h_i};
  assign x_clip = (x_sum > MAP_W9) ? MAP_W9 : x_sum;
  assign y_clip = (y_sum > MAP_H9) ? MAP_H9 : y_sum;
  assign empty  = ({1'b0, cmd_x0_i} >= MAP_W9) || ({2'b0, cmd_y0_i} >= MAP_H9) ||
                  (cmd_w_i == 8'd0) || (cmd_h_i == 7'd0);

  // y*160 as y*128 + y*32, so the start row needs no multiplier.
  assign row_init = ADDR_W'({cmd_y0_i, 7'b0}) + ADDR_W'({cmd_y0_i, 5'b0});
  assign addr     = row_q + ADDR_W'(x_q);
  assign x_last   = (x_q + 9'd1) == x_end_q;
  assign last     = x_last && ((y_q + 9'd1) == y_end_q);
  assign step     = (state_q == S_FILL) || (state_q == S_CMP);

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = empty ? S_DONE : (cmd_recolor_i ? S_RD : S_FILL);
      S_FILL: if (last) state_d = S_DONE;
      S_RD:   state_d = S_CMP;
      S_CMP:  state_d = last ? S_DONE : S_RD;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_addr_o = '0;
    wr_en_o   = 1'b0;
    wr_addr_o = '0;
    wr_data_o = '0;
    case (state_q)
      S_FILL: begin
        wr_en_o   = 1'b1;
        wr_addr_o = addr;
        wr_data_o = color_q;
      end
      S_RD: rd_addr_o = addr;
      S_CMP: if (rd_data_i == match_q) begin
        wr_en_o   = 1'b1;
        wr_addr_o = addr;
        wr_data_o = color_q;
      end
      default: ;
    endcase
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_q     <= '0;
      x0_q    <= '0;
      x_end_q <= '0;
      y_q     <= '0;
      y_end_q <= '0;
      row_q   <= '0;
      color_q <= '0;
      match_q <= '0;
    end else if (accept) begin
      x_q     <= {1'b0, cmd_x0_i};
      x0_q    <= {1'b0, cmd_x0_i};
      x_end_q <= x_clip;
      y_q     <= {2'b0, cmd_y0_i};
      y_end_q <= y_clip;
      row_q   <= row_init;
      color_q <= cmd_color_i;
      match_q <= cmd_match_i;
    end else if (step) begin
      if (x_last) begin
        x_q   <= x0_q;
        y_q   <= y_q + 9'd1;
        row_q <= row_q + ADDR_W'(MAP_W);
      end else begin
        x_q <= x_q + 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_map_rect_writer.sv
// Randomized and directed checks of map_rect_writer against a pixel-loop reference model
// and a behavioural 1-cycle-latency map RAM.
module tb_map_rect_writer;

  localparam int NPIX = 160 * 120;

  typedef struct {
    int x0; int y0; int w; int h; int color; int recolor; int match;
  } cmd_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        init_req = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_x0 = '0;
  logic [6:0]  cmd_y0 = '0;
  logic [7:0]  cmd_w = '0;
  logic [6:0]  cmd_h = '0;
  logic [3:0]  cmd_color = '0;
  logic        cmd_recolor = 1'b0;
  logic [3:0]  cmd_match = '0;
  logic [16:0] rd_addr;
  logic [3:0]  rd_data = '0;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [3:0]  wr_data;
  logic        busy;
  logic        done;

  logic [3:0]  mem     [0:NPIX-1];
  logic [3:0]  ref_mem [0:NPIX-1];

  int n_tests = 0;
  int n_fail  = 0;

  map_rect_writer dut (
    .clk_i(clk), .reset_i(reset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_x0_i(cmd_x0), .cmd_y0_i(cmd_y0), .cmd_w_i(cmd_w), .cmd_h_i(cmd_h),
    .cmd_color_i(cmd_color), .cmd_recolor_i(cmd_recolor), .cmd_match_i(cmd_match),
    .rd_addr_o(rd_addr), .rd_data_i(rd_data),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  function automatic int pat(input int i);
    case (i)
      0: return 0;
      1: return 1;
      2: return 0;
      3: return 2;
      default: return (i * 5 + i / 11) % 4;
    endcase
  endfunction

  // Map RAM: synchronous read with 1-cycle latency, write port from the DUT.
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < NPIX; i++) mem[i] <= 4'(pat(i));
    end else if (wr_en && int'(wr_addr) < NPIX) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= (int'(rd_addr) < NPIX) ? mem[rd_addr] : 4'd0;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ram_diffs();
    int d = 0;
    for (int i = 0; i < NPIX; i++) if (mem[i] !== ref_mem[i]) d++;
    return d;
  endfunction

  task automatic drive(input cmd_t c);
    cmd_x0      = 8'(c.x0);
    cmd_y0      = 7'(c.y0);
    cmd_w       = 8'(c.w);
    cmd_h       = 7'(c.h);
    cmd_color   = 4'(c.color);
    cmd_recolor = c.recolor[0];
    cmd_match   = 4'(c.match);
  endtask

  task automatic issue(input cmd_t c);
    int waited = 0;
    @(negedge clk);
    drive(c);
    cmd_valid = 1'b1;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("ready_idle", int'(cmd_ready), 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Called right after the accepting edge; follows the command until one cycle past done.
  task automatic track(input cmd_t c, input bit hold);
    int ex_a[$], ex_d[$], ex_k[$], ex_rd[$];
    int got_a[$], got_d[$], got_k[$], got_rd[$];
    int xe, ye, n, exp_done, done_k, busy_bad, ready_bad, a, m;
    xe = (c.x0 + c.w > 160) ? 160 : c.x0 + c.w;
    ye = (c.y0 + c.h > 120) ? 120 : c.y0 + c.h;
    n = 0;
    for (int y = c.y0; y < ye; y++) begin
      for (int x = c.x0; x < xe; x++) begin
        a = y * 160 + x;
        if (c.recolor != 0) begin
          ex_rd.push_back(a);
          if (int'(ref_mem[a]) == c.match) begin
            ex_a.push_back(a); ex_d.push_back(c.color); ex_k.push_back(2 * n + 2);
            ref_mem[a] = 4'(c.color);
          end
        end else begin
          ex_a.push_back(a); ex_d.push_back(c.color); ex_k.push_back(n + 1);
          ref_mem[a] = 4'(c.color);
        end
        n++;
      end
    end
    exp_done = (n == 0) ? 1 : ((c.recolor != 0) ? 2 * n + 1 : n + 1);
    done_k = -1; busy_bad = 0; ready_bad = 0;
    for (int k = 1; k <= exp_done + 20; k++) begin
      @(negedge clk);
      if (wr_en) begin
        got_a.push_back(int'(wr_addr)); got_d.push_back(int'(wr_data)); got_k.push_back(k);
      end
      if (c.recolor != 0 && (k % 2) == 1 && k < 2 * n) got_rd.push_back(int'(rd_addr));
      if (!busy) busy_bad++;
      if (hold && cmd_ready) ready_bad++;
      if (done) begin
        done_k = k;
        break;
      end
    end
    check("done_cycle", done_k, exp_done);
    check("write_count", got_a.size(), ex_a.size());
    m = (got_a.size() < ex_a.size()) ? got_a.size() : ex_a.size();
    for (int i = 0; i < m; i++) begin
      check("wr_addr", got_a[i], ex_a[i]);
      check("wr_data", got_d[i], ex_d[i]);
      check("wr_cycle", got_k[i], ex_k[i]);
    end
    if (c.recolor != 0) begin
      check("rd_count", got_rd.size(), ex_rd.size());
      m = (got_rd.size() < ex_rd.size()) ? got_rd.size() : ex_rd.size();
      for (int i = 0; i < m; i++) check("rd_addr", got_rd[i], ex_rd[i]);
    end
    check("busy_during", busy_bad, 0);
    if (hold) check("ready_low_busy", ready_bad, 0);
    @(negedge clk);
    check("done_width", int'(done), 0);
    check("ready_after", int'(cmd_ready), 1);
    check("ram_contents", ram_diffs(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    cmd_t c, c2;
    int nwr, ndone;
    for (int i = 0; i < NPIX; i++) ref_mem[i] = 4'(pat(i));
    repeat (2) @(posedge clk);
    #1 init_req = 1'b0;
    @(negedge clk);
    check("rst_ready", int'(cmd_ready), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // RECOLOR over {0,1,0,2}: 0 -> 8
    c = '{x0: 0, y0: 0, w: 4, h: 1, color: 8, recolor: 1, match: 0};
    issue(c); track(c, 1'b0);
    check("recolor_m0", int'(mem[0]), 8);
    check("recolor_m1", int'(mem[1]), 1);
    check("recolor_m2", int'(mem[2]), 8);
    check("recolor_m3", int'(mem[3]), 2);

    c = '{x0: 2, y0: 3, w: 3, h: 2, color: 7, recolor: 0, match: 0};
    issue(c); track(c, 1'b0);
    check("fill_482", int'(mem[482]), 7);
    check("fill_644", int'(mem[644]), 7);

    c = '{x0: 158, y0: 119, w: 4, h: 4, color: 5, recolor: 0, match: 0};
    issue(c); track(c, 1'b0);
    check("clip_19199", int'(mem[19199]), 5);

    c = '{x0: 10, y0: 10, w: 0, h: 3, color: 6, recolor: 0, match: 0};
    issue(c); track(c, 1'b0);
    c = '{x0: 160, y0: 10, w: 5, h: 3, color: 6, recolor: 0, match: 0};
    issue(c); track(c, 1'b0);
    c = '{x0: 10, y0: 120, w: 5, h: 3, color: 6, recolor: 1, match: 1};
    issue(c); track(c, 1'b0);

    // Second command held on the bus while a 10x10 fill runs.
    c  = '{x0: 30, y0: 40, w: 10, h: 10, color: 9, recolor: 0, match: 0};
    c2 = '{x0: 100, y0: 100, w: 5, h: 2, color: 3, recolor: 0, match: 0};
    issue(c);
    drive(c2);
    cmd_valid = 1'b1;
    track(c, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    track(c2, 1'b0);

    // Reset pulse during the 5th write of a 10x1 fill.
    c = '{x0: 20, y0: 50, w: 10, h: 1, color: 12, recolor: 0, match: 0};
    issue(c);
    nwr = 0; ndone = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (wr_en) nwr++;
      if (done) ndone++;
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_wr_en", int'(wr_en), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(cmd_ready), 1);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (wr_en) nwr++;
      if (done) ndone++;
    end
    check("abort_writes", nwr, 5);
    check("abort_done", ndone, 0);
    for (int x = 20; x < 25; x++) ref_mem[50 * 160 + x] = 4'd12;
    check("abort_ram", ram_diffs(), 0);

    for (int t = 0; t < 40; t++) begin
      c.x0      = int'($urandom_range(0, 170));
      c.y0      = int'($urandom_range(0, 125));
      c.w       = int'($urandom_range(0, 12));
      c.h       = int'($urandom_range(0, 6));
      c.color   = int'($urandom_range(0, 15));
      c.recolor = int'($urandom_range(0, 1));
      c.match   = int'($urandom_range(0, 3));
      if (t % 8 == 0) begin
        c.x0 = int'($urandom_range(150, 159));
        c.y0 = int'($urandom_range(114, 119));
      end
      issue(c); track(c, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
